// File: rtl/neuron_layer_if.sv
// Stream/result bundle between a neuron_layer and its memories plus consumer.
// The master side drives start and memory data; the slave (the layer) drives address and results.
interface neuron_layer_if #(
   parameter int N  = 9,
   parameter int M  = 4,
   parameter int DW = 8
);
   localparam int ACCW = 2*DW + $clog2(N);

   logic                 start;
   logic [DW-1:0]        x_in;
   logic [M*DW-1:0]      w_in;
   logic [31:0]          adr;
   logic                 busy;
   logic                 done;
   logic [M*ACCW-1:0]    y_out;

   modport master (output start, x_in, w_in, input adr, busy, done, y_out);
   modport slave  (input start, x_in, w_in, output adr, busy, done, y_out);
endinterface

// File: rtl/neuron_layer.sv
// Layer of M multiply-accumulate neurons sharing one input stream over N address steps.
// Optional ReLU on the published results when NEURON_LAYER_RELU_EN is defined.
module neuron_layer #(
   parameter int N  = 9,
   parameter int M  = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   neuron_layer_if.slave nl
);
   localparam int ACCW = 2*DW + $clog2(N);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t                  state_q, state_d;
   logic [31:0]             adr_q, adr_d;
   logic signed [ACCW-1:0]  acc_q [M];
   logic signed [ACCW-1:0]  acc_d [M];
   logic signed [ACCW-1:0]  prod  [M];
   logic [M*ACCW-1:0]       y_q, y_d;
   logic signed [ACCW-1:0]  x_ext;
   logic                    last;

   function automatic logic signed [ACCW-1:0] act(input logic signed [ACCW-1:0] v);
`ifdef NEURON_LAYER_RELU_EN
      act = v[ACCW-1] ? '0 : v;
`else
      act = v;
`endif
   endfunction

   assign last  = (adr_q == 32'(N-1));
   assign x_ext = {{(ACCW-DW){nl.x_in[DW-1]}}, nl.x_in};

   // Operands are sign-extended to ACCW first so the product is formed at full accumulator width.
   always_comb begin
      for (int j = 0; j < M; j++) begin
         prod[j] = x_ext * $signed({{(ACCW-DW){nl.w_in[j*DW+DW-1]}}, nl.w_in[j*DW +: DW]});
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         adr_q   <= '0;
         y_q     <= '0;
         for (int j = 0; j < M; j++) acc_q[j] <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         y_q     <= y_d;
         for (int j = 0; j < M; j++) acc_q[j] <= acc_d[j];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (nl.start) state_d = ACC;
         ACC:     if (last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Accumulators and address return to zero whenever not mid-walk, so a new run starts clean.
   always_comb begin
      adr_d = '0;
      y_d   = y_q;
      for (int j = 0; j < M; j++) acc_d[j] = '0;
      if (state_q == ACC) begin
         if (last) begin
            for (int j = 0; j < M; j++) y_d[j*ACCW +: ACCW] = act(acc_q[j] + prod[j]);
         end else begin
            adr_d = adr_q + 32'd1;
            for (int j = 0; j < M; j++) acc_d[j] = acc_q[j] + prod[j];
         end
      end
   end

   always_comb begin
      nl.busy  = (state_q == ACC) || (state_q == DONE);
      nl.done  = (state_q == DONE);
      nl.adr   = adr_q;
      nl.y_out = y_q;
   end
endmodule

// File: tb/tb_neuron_layer.sv
// Self-checking bench for neuron_layer: vector table, random runs against an integer model,
// and hand-written sequences for busy restart, mid-run reset and continuous start.
module tb_neuron_layer;
   localparam int N    = 9;
   localparam int M    = 4;
   localparam int DW   = 8;
   localparam int ACCW = 2*DW + $clog2(N);

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   int          xmem [N];
   int          wmem [N][M];
   logic signed [63:0] expq [M];

   typedef struct {
      string              nm;
      int                 x;
      logic [M-1:0][7:0]  w;
      logic [M-1:0][31:0] e;
      logic [M-1:0][31:0] er;
   } vec_t;

   vec_t tbl [4];

   neuron_layer_if #(.N(N), .M(M), .DW(DW)) bus ();

   neuron_layer #(.N(N), .M(M), .DW(DW)) dut (
      .clk(clk),
      .rst(rst_n),
      .nl (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      int a;
      a = (bus.adr < 32'(N)) ? int'(bus.adr) : 0;
      bus.x_in = DW'(xmem[a]);
      bus.w_in = '0;
      for (int j = 0; j < M; j++) bus.w_in[j*DW +: DW] = DW'(wmem[a][j]);
   end

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic signed [63:0] lane(int j);
      return 64'($signed(bus.y_out[j*ACCW +: ACCW]));
   endfunction

   function automatic logic signed [63:0] model_lane(int j);
      longint s = 0;
      for (int k = 0; k < N; k++) s += longint'(xmem[k]) * longint'(wmem[k][j]);
`ifdef NEURON_LAYER_RELU_EN
      if (s < 0) s = 0;
`endif
      return 64'(s);
   endfunction

   task automatic load_vec(input int i);
      for (int k = 0; k < N; k++) begin
         xmem[k] = tbl[i].x;
         for (int j = 0; j < M; j++) wmem[k][j] = int'($signed(tbl[i].w[j]));
      end
      for (int j = 0; j < M; j++) begin
`ifdef NEURON_LAYER_RELU_EN
         expq[j] = 64'($signed(tbl[i].er[j]));
`else
         expq[j] = 64'($signed(tbl[i].e[j]));
`endif
      end
   endtask

   task automatic check_lanes(input string nm);
      for (int j = 0; j < M; j++) chk($sformatf("%s lane%0d", nm, j), lane(j), expq[j]);
   endtask

   // One evaluation; extra_k > 0 re-asserts start during cycle T0+extra_k.
   task automatic eval_and_check(input string nm, input int extra_k);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= N; k++) begin
         @(negedge clk);
         bus.start = (k == extra_k);
         chk($sformatf("%s adr@%0d", nm, k), 64'(bus.adr), 64'(k-1));
         chk($sformatf("%s done@%0d", nm, k), 64'(bus.done), 0);
         if (k == 1) chk($sformatf("%s busy@1", nm), 64'(bus.busy), 1);
      end
      @(negedge clk);
      bus.start = 1'b0;
      chk($sformatf("%s done@%0d", nm, N+1), 64'(bus.done), 1);
      chk($sformatf("%s busy@%0d", nm, N+1), 64'(bus.busy), 1);
      chk($sformatf("%s adr@%0d", nm, N+1), 64'(bus.adr), 0);
      check_lanes(nm);
      @(negedge clk);
      chk($sformatf("%s done_after", nm), 64'(bus.done), 0);
      chk($sformatf("%s busy_after", nm), 64'(bus.busy), 0);
      check_lanes($sformatf("%s hold", nm));
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      for (int k = 0; k < N; k++) begin
         xmem[k] = 0;
         for (int j = 0; j < M; j++) wmem[k][j] = 0;
      end

      tbl[0].nm = "basic";   tbl[0].x = 1;
      tbl[0].w  = {8'd4, 8'd3, 8'd2, 8'd1};
      tbl[0].e  = {32'd36, 32'd27, 32'd18, 32'd9};
      tbl[0].er = {32'd36, 32'd27, 32'd18, 32'd9};
      tbl[1].nm = "negative"; tbl[1].x = -2;
      tbl[1].w  = {8'd5, 8'd0, 8'hFF, 8'd3};
      tbl[1].e  = {-32'sd90, 32'd0, 32'd18, -32'sd54};
      tbl[1].er = {32'd0, 32'd0, 32'd18, 32'd0};
      tbl[2].nm = "extremes"; tbl[2].x = -128;
      tbl[2].w  = {8'h80, 8'h80, 8'h80, 8'h80};
      tbl[2].e  = {32'd147456, 32'd147456, 32'd147456, 32'd147456};
      tbl[2].er = {32'd147456, 32'd147456, 32'd147456, 32'd147456};
      tbl[3].nm = "maxpos";  tbl[3].x = 127;
      tbl[3].w  = {8'h7F, 8'h80, 8'h7F, 8'h80};
      tbl[3].e  = {32'd145161, -32'sd146304, 32'd145161, -32'sd146304};
      tbl[3].er = {32'd145161, 32'd0, 32'd145161, 32'd0};

      repeat (2) @(negedge clk);
      chk("rst adr", 64'(bus.adr), 0);
      chk("rst busy", 64'(bus.busy), 0);
      chk("rst done", 64'(bus.done), 0);
      for (int j = 0; j < M; j++) chk($sformatf("rst lane%0d", j), lane(j), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         load_vec(i);
         eval_and_check(tbl[i].nm, 0);
      end

      load_vec(0);
      eval_and_check("start_busy", 3);

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < N; k++) begin
            xmem[k] = int'($urandom_range(255)) - 128;
            for (int j = 0; j < M; j++) wmem[k][j] = int'($urandom_range(255)) - 128;
         end
         for (int j = 0; j < M; j++) expq[j] = model_lane(j);
         eval_and_check($sformatf("rand%0d", r), 0);
      end

      // Abort at adr = 4; the random result on y_out must vanish at once.
      load_vec(0);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst adr_before", 64'(bus.adr), 4);
      rst_n = 1'b0;
      #1;
      chk("midrst adr", 64'(bus.adr), 0);
      chk("midrst busy", 64'(bus.busy), 0);
      chk("midrst done", 64'(bus.done), 0);
      for (int j = 0; j < M; j++) chk($sformatf("midrst lane%0d", j), lane(j), 0);
      @(negedge clk);
      rst_n = 1'b1;
      eval_and_check("after_rst", 0);

      load_vec(2);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 33; c++) begin
         @(negedge clk);
         chk($sformatf("cont done@%0d", c), 64'(bus.done), 64'((c % 11) == 10));
         chk($sformatf("cont busy@%0d", c), 64'(bus.busy), 64'((c % 11) != 0));
         if (c >= 10) check_lanes($sformatf("cont@%0d", c));
      end
      bus.start = 1'b0;
      repeat (12) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
